instruction_memory_loadable: RTL and testbench

Parametrised instruction memory for the MIPS single-cycle datapath, replacing the fixed 32-word combinational ROM. It adds a registered fetch port with a valid flag. A sequential program-load port writes a block of words from a testbench or boot source at run time, with an auto-incrementing pointer and a valid/ready handshake. Optional bounds checking flags misaligned or out-of-range fetches.

---
 rtl/instruction_memory_loadable.sv | 123 ++++++++++++
 tb/tb_instruction_memory_loadable.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_loadable.sv
// Loadable instruction memory: registered fetch port plus a sequential block-load port.
// Optional fetch bounds checking is enabled by defining IMEM_BOUNDS_CHECK_EN.
module instruction_memory_loadable #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] A,
  input  logic              fetch_req,
  output logic [DATA_W-1:0] RD,
  output logic              rd_valid,
  output logic              fault,
  input  logic              load_start,
  input  logic [IW-1:0]     load_base,
  input  logic [IW:0]       load_count,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW:0]         rem_q, rem_d;
  logic [DATA_W-1:0]   rd_q;
  logic                rd_valid_q;
  logic                fault_q;
  logic [DATA_W-1:0]   mem_q [DEPTH] = '{default: '0};

  logic [IW-1:0]       fetch_idx;
  logic                fetch_acc;
  logic                addr_bad;
  logic                wr_en;

  // Load handshake: a word transfers on any cycle where load_valid and
  // load_ready are both high; load_ready is high exactly while in LOAD.
  assign load_ready = (state_q == LOAD);
  assign load_busy  = (state_q == LOAD);
  assign load_done  = (state_q == DONE);
  assign state_o    = state_q;

  assign fetch_idx = A[IW+1:2];
  assign fetch_acc = fetch_req && (state_q != LOAD);
  assign wr_en     = rst_n && load_valid && (state_q == LOAD);

`ifdef IMEM_BOUNDS_CHECK_EN
  assign addr_bad = (A[1:0] != 2'b00) || (|A[ADDR_W-1:IW+2]);
`else
  // Byte offset and high index bits alias away when checking is off.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{A[ADDR_W-1:IW+2], A[1:0]};
  assign addr_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (load_start && (load_count != '0)) begin
          state_d = LOAD;
          ptr_d   = load_base;
          rem_d   = load_count;
        end
      end
      LOAD: begin
        if (load_valid) begin
          ptr_d = ptr_q + IW'(1);
          rem_d = rem_q - (IW+1)'(1);
          if (rem_q == (IW+1)'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      rd_valid_q <= fetch_acc;
      fault_q    <= fetch_acc && addr_bad;
      if (fetch_acc) rd_q <= addr_bad ? '0 : mem_q[fetch_idx];
    end
  end

  // Memory contents survive reset; only the write enable is held off.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[ptr_q] <= load_data;
  end

  assign RD       = rd_q;
  assign rd_valid = rd_valid_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_instruction_memory_loadable.sv
// Directed self-checking bench for instruction_memory_loadable (DEPTH = 32).
// Covers both builds: bounds checks follow IMEM_BOUNDS_CHECK_EN.
module tb_instruction_memory_loadable;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 32;
  localparam int IW     = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] A;
  logic              fetch_req;
  logic [DATA_W-1:0] RD;
  logic              rd_valid;
  logic              fault;
  logic              load_start;
  logic [IW-1:0]     load_base;
  logic [IW:0]       load_count;
  logic [DATA_W-1:0] load_data;
  logic              load_valid;
  logic              load_ready;
  logic              load_busy;
  logic              load_done;
  logic [1:0]        state_o;

  int n_checks = 0;
  int n_errors = 0;

  instruction_memory_loadable #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .fetch_req(fetch_req),
    .RD(RD), .rd_valid(rd_valid), .fault(fault),
    .load_start(load_start), .load_base(load_base), .load_count(load_count),
    .load_data(load_data), .load_valid(load_valid), .load_ready(load_ready),
    .load_busy(load_busy), .load_done(load_done), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_block(input logic [IW-1:0] base, input logic [IW:0] count,
                            input logic [DATA_W-1:0] first);
    load_start = 1'b1; load_base = base; load_count = count;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < int'(count); i++) begin
      load_valid = 1'b1; load_data = first + DATA_W'(i);
      tick();
    end
    load_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_checks++;
    if ({RD, rd_valid, fault} !== {32'h0, 1'b0, 1'b0}) begin
      n_errors++; $display("FAIL reset_fetch: RD=%h v=%b f=%b, want 0/0/0", RD, rd_valid, fault);
    end
    n_checks++;
    if ({load_ready, load_busy, load_done, state_o} !== 5'b00000) begin
      n_errors++; $display("FAIL reset_load: rdy=%b busy=%b done=%b st=%0d, want 0/0/0/0",
                           load_ready, load_busy, load_done, state_o);
    end
    rst_n = 1'b1;
    tick();
    A = 32'h0; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    n_checks++;
    if ({RD, rd_valid, fault} !== {32'h0, 1'b1, 1'b0}) begin
      n_errors++; $display("FAIL reset_first_fetch: RD=%h v=%b f=%b, want 00000000/1/0", RD, rd_valid, fault);
    end
  endtask

  task automatic test_load_basic();
    logic [DATA_W-1:0] exp_w [4];
    exp_w = '{32'h20080001, 32'h20080002, 32'h20080003, 32'h20080004};
    load_start = 1'b1; load_base = 5'd0; load_count = 6'd4;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({load_busy, load_ready, load_done} !== 3'b110) begin
        n_errors++; $display("FAIL basic_busy[%0d]: busy=%b rdy=%b done=%b, want 1/1/0",
                             i, load_busy, load_ready, load_done);
      end
      load_valid = 1'b1; load_data = exp_w[i];
      tick();
    end
    load_valid = 1'b0;
    // Cycle 5: done pulse, and a fetch issued here must be served.
    n_checks++;
    if ({load_busy, load_done} !== 2'b01) begin
      n_errors++; $display("FAIL basic_done: busy=%b done=%b, want 0/1", load_busy, load_done);
    end
    for (int i = 0; i < 4; i++) begin
      A = 32'(i * 4); fetch_req = 1'b1;
      tick();
      n_checks++;
      if ({RD, rd_valid} !== {exp_w[i], 1'b1}) begin
        n_errors++; $display("FAIL basic_fetch[%0d]: RD=%h v=%b, want %h/1", i, RD, rd_valid, exp_w[i]);
      end
      if (i == 0) begin
        n_checks++;
        if (load_done !== 1'b0) begin
          n_errors++; $display("FAIL basic_done_width: done=%b, want 0", load_done);
        end
      end
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_load_wrap();
    logic [DATA_W-1:0] exp_w [5];
    logic [ADDR_W-1:0] addr [5];
    exp_w = '{32'h300000A0, 32'h300000A1, 32'h300000A2, 32'h300000A3, 32'h20080003};
    addr  = '{32'd120, 32'd124, 32'd0, 32'd4, 32'd8};
    load_start = 1'b1; load_base = 5'd30; load_count = 6'd4;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = exp_w[i];
      tick();
    end
    load_valid = 1'b0; fetch_req = 1'b1; A = 32'h0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({rd_valid, load_busy, load_done} !== 3'b010) begin
        n_errors++; $display("FAIL wrap_gap[%0d]: v=%b busy=%b done=%b, want 0/1/0",
                             i, rd_valid, load_busy, load_done);
      end
    end
    fetch_req = 1'b0;
    for (int i = 2; i < 4; i++) begin
      load_valid = 1'b1; load_data = exp_w[i];
      tick();
    end
    load_valid = 1'b0;
    n_checks++;
    if ({load_busy, load_done} !== 2'b01) begin
      n_errors++; $display("FAIL wrap_done: busy=%b done=%b, want 0/1", load_busy, load_done);
    end
    for (int i = 0; i < 5; i++) begin
      A = addr[i]; fetch_req = 1'b1;
      tick();
      n_checks++;
      if ({RD, rd_valid} !== {exp_w[i], 1'b1}) begin
        n_errors++; $display("FAIL wrap_fetch[%0d]: RD=%h v=%b, want %h/1", i, RD, rd_valid, exp_w[i]);
      end
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_fetch_and_load();
    A = 32'h0; fetch_req = 1'b1;
    load_start = 1'b1; load_base = 5'd4; load_count = 6'd1;
    tick();
    fetch_req = 1'b0; load_start = 1'b0;
    n_checks++;
    if ({RD, rd_valid, load_ready, load_busy} !== {32'h300000A2, 3'b111}) begin
      n_errors++; $display("FAIL same_cycle: RD=%h v=%b rdy=%b busy=%b, want 300000a2/1/1/1",
                           RD, rd_valid, load_ready, load_busy);
    end
    load_valid = 1'b1; load_data = 32'hCAFE0004;
    tick();
    load_valid = 1'b0;
    A = 32'd16; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    n_checks++;
    if ({RD, rd_valid} !== {32'hCAFE0004, 1'b1}) begin
      n_errors++; $display("FAIL fetch_in_done: RD=%h v=%b, want cafe0004/1", RD, rd_valid);
    end
  endtask

  task automatic test_zero_count();
    load_start = 1'b1; load_base = 5'd3; load_count = 6'd0;
    tick();
    load_start = 1'b0;
    n_checks++;
    if ({load_busy, load_ready, state_o} !== 4'b0000) begin
      n_errors++; $display("FAIL zero_count: busy=%b rdy=%b st=%0d, want 0/0/0", load_busy, load_ready, state_o);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [DATA_W-1:0] exp_w [5];
    exp_w = '{32'h22220008, 32'h22220009, 32'h1111000A, 32'h1111000B, 32'h1111000C};
    load_block(5'd8, 6'd5, 32'h11110008);
    load_start = 1'b1; load_base = 5'd8; load_count = 6'd5;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = 32'h22220008 + DATA_W'(i);
      tick();
    end
    load_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if ({load_busy, load_done, state_o} !== 4'b0000) begin
      n_errors++; $display("FAIL midload_reset: busy=%b done=%b st=%0d, want 0/0/0", load_busy, load_done, state_o);
    end
    for (int i = 0; i < 5; i++) begin
      A = 32'((8 + i) * 4); fetch_req = 1'b1;
      tick();
      n_checks++;
      if ({RD, rd_valid, load_done} !== {exp_w[i], 2'b10}) begin
        n_errors++; $display("FAIL midload_fetch[%0d]: RD=%h v=%b done=%b, want %h/1/0",
                             i, RD, rd_valid, load_done, exp_w[i]);
      end
    end
    fetch_req = 1'b0;
  endtask

  task automatic test_bounds();
`ifdef IMEM_BOUNDS_CHECK_EN
    A = 32'h6; fetch_req = 1'b1;
    tick();
    n_checks++;
    if ({RD, rd_valid, fault} !== {32'h0, 2'b11}) begin
      n_errors++; $display("FAIL bounds_misaligned: RD=%h v=%b f=%b, want 0/1/1", RD, rd_valid, fault);
    end
    A = 32'h80;
    tick();
    n_checks++;
    if ({RD, rd_valid, fault} !== {32'h0, 2'b11}) begin
      n_errors++; $display("FAIL bounds_range: RD=%h v=%b f=%b, want 0/1/1", RD, rd_valid, fault);
    end
`else
    A = 32'h80; fetch_req = 1'b1;
    tick();
    n_checks++;
    if ({RD, rd_valid, fault} !== {32'h300000A2, 2'b10}) begin
      n_errors++; $display("FAIL alias_80: RD=%h v=%b f=%b, want 300000a2/1/0", RD, rd_valid, fault);
    end
    A = 32'h0000_1086;
    tick();
    n_checks++;
    if ({RD, rd_valid, fault} !== {32'h300000A3, 2'b10}) begin
      n_errors++; $display("FAIL alias_1086: RD=%h v=%b f=%b, want 300000a3/1/0", RD, rd_valid, fault);
    end
`endif
    A = 32'h8;
    tick();
    fetch_req = 1'b0;
    n_checks++;
    if ({RD, rd_valid, fault} !== {32'h20080003, 2'b10}) begin
      n_errors++; $display("FAIL bounds_ok: RD=%h v=%b f=%b, want 20080003/1/0", RD, rd_valid, fault);
    end
  endtask

  initial begin
    rst_n = 1'b0; A = '0; fetch_req = 1'b0;
    load_start = 1'b0; load_base = '0; load_count = '0;
    load_data = '0; load_valid = 1'b0;
    test_reset();
    test_load_basic();
    test_load_wrap();
    test_fetch_and_load();
    test_zero_count();
    test_reset_mid_load();
    test_bounds();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
